// File: rtl/pipe_pkg.sv
// Shared constants and types for parametrised pipeline boundary registers.
// Control bit positions follow the {MemWrite, MemtoReg, RegWrite} layout.
package pipe_pkg;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;

    localparam int unsigned PIPE_CTRL_W = 3;
    localparam int unsigned PIPE_RD_W   = 5;

    // Side-effecting bits that must never survive in an invalid slot
    localparam logic [PIPE_CTRL_W-1:0] KILL_MASK_DEFAULT =
        PIPE_CTRL_W'((1 << CTRL_MEMWRITE) | (1 << CTRL_REGWRITE));

    localparam int unsigned ZERO_REG_DEFAULT = 31;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_RD_W-1:0]   rd;
    } stage_hdr_t;

endpackage

// File: rtl/pipe_stage_slice.sv
// One pipeline register stage: async clear, hold, bubble load or normal load.
// Control is masked on capture whenever the captured slot is not valid.
module pipe_stage_slice #(
    parameter int unsigned      DATA_W    = 64,
    parameter int unsigned      N_DATA    = 2,
    parameter int unsigned      CTRL_W    = 3,
    parameter int unsigned      RD_W      = 5,
    parameter logic [CTRL_W-1:0] KILL_MASK = 3'b101
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_hold,
    input  logic                     i_bubble,
    input  logic                     i_valid,
    input  logic [N_DATA*DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0]        i_ctrl,
    input  logic [RD_W-1:0]          i_rd,
    output logic                     o_valid,
    output logic [N_DATA*DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0]        o_ctrl,
    output logic [RD_W-1:0]          o_rd
);

    localparam int unsigned DW = N_DATA * DATA_W;

    logic              w_load_valid;
    logic [DW-1:0]     w_load_data;
    logic [CTRL_W-1:0] w_load_ctrl;
    logic [RD_W-1:0]   w_load_rd;

    logic              r_valid;
    logic [DW-1:0]     r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic [RD_W-1:0]   r_rd;

    // A flush bubble clears payload; a plain invalid slot keeps data/rd for debug
    always_comb begin
        w_load_valid = i_valid & ~i_bubble;
        w_load_data  = i_bubble ? '0 : i_data;
        w_load_rd    = i_bubble ? '0 : i_rd;
        w_load_ctrl  = w_load_valid ? i_ctrl : (i_ctrl & ~KILL_MASK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_rd    <= '0;
        end else if (!i_hold) begin
            r_valid <= w_load_valid;
            r_data  <= w_load_data;
            r_ctrl  <= w_load_ctrl;
            r_rd    <= w_load_rd;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;
    assign o_rd    = r_rd;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised multi-stage pipeline boundary register with stall/flush,
// effective RegWrite for the forwarding unit and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       N_DATA      = 2,
    parameter int unsigned       CTRL_W      = 3,
    parameter int unsigned       RD_W        = 5,
    parameter int unsigned       DEPTH       = 1,
    parameter logic [CTRL_W-1:0] KILL_MASK   = CTRL_W'(KILL_MASK_DEFAULT),
    parameter int unsigned       ZERO_REG    = ZERO_REG_DEFAULT,
    parameter int unsigned       STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [N_DATA*DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0]        control_in,
    input  logic [RD_W-1:0]          rd_in,
    output logic                     valid_out,
    output logic [N_DATA*DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0]        control_out,
    output logic [RD_W-1:0]          rd_out,
    output logic                     regwrite_eff,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);

    localparam int unsigned DW = N_DATA * DATA_W;

    logic              w_hold;
    logic              w_valid [DEPTH];
    logic [DW-1:0]     w_data  [DEPTH];
    logic [CTRL_W-1:0] w_ctrl  [DEPTH];
    logic [RD_W-1:0]   w_rd    [DEPTH];

    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Flush overrides stall, so the whole chain advances on a flush edge
    assign w_hold = stall & ~flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_stage_slice #(
                .DATA_W    (DATA_W),
                .N_DATA    (N_DATA),
                .CTRL_W    (CTRL_W),
                .RD_W      (RD_W),
                .KILL_MASK (KILL_MASK)
            ) u_slice (
                .clk      (clk),
                .reset    (reset),
                .i_hold   (w_hold),
                .i_bubble (flush),
                .i_valid  (valid_in),
                .i_data   (data_in),
                .i_ctrl   (control_in),
                .i_rd     (rd_in),
                .o_valid  (w_valid[k]),
                .o_data   (w_data[k]),
                .o_ctrl   (w_ctrl[k]),
                .o_rd     (w_rd[k])
            );
        end else begin : g_next
            pipe_stage_slice #(
                .DATA_W    (DATA_W),
                .N_DATA    (N_DATA),
                .CTRL_W    (CTRL_W),
                .RD_W      (RD_W),
                .KILL_MASK (KILL_MASK)
            ) u_slice (
                .clk      (clk),
                .reset    (reset),
                .i_hold   (w_hold),
                .i_bubble (1'b0),
                .i_valid  (w_valid[k-1]),
                .i_data   (w_data[k-1]),
                .i_ctrl   (w_ctrl[k-1]),
                .i_rd     (w_rd[k-1]),
                .o_valid  (w_valid[k]),
                .o_data   (w_data[k]),
                .o_ctrl   (w_ctrl[k]),
                .o_rd     (w_rd[k])
            );
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_hold && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign valid_out   = w_valid[DEPTH-1];
    assign data_out    = w_data[DEPTH-1];
    assign control_out = w_ctrl[DEPTH-1];
    assign rd_out      = w_rd[DEPTH-1];
    assign stall_cnt   = r_stall_cnt;

    // XZR suppression only on the output view; the stored rd stays visible
    assign regwrite_eff = valid_out & control_out[CTRL_REGWRITE]
                        & (rd_out != RD_W'(ZERO_REG));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three depth variants driven in lockstep and
// compared against a queue-of-captured-slots reference model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic         valid;
        logic [127:0] data;
        logic [2:0]   ctrl;
        logic [4:0]   rd;
    } slot_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic         flush;
    logic         valid_in;
    logic [127:0] data_in;
    logic [2:0]   control_in;
    logic [4:0]   rd_in;

    logic         v1, v2, v3;
    logic [127:0] d1, d2, d3;
    logic [2:0]   c1, c2, c3;
    logic [4:0]   r1, r2, r3;
    logic         rw1, rw2, rw3;
    logic [15:0]  sc1, sc2;
    logic [3:0]   sc3;

    int    errors = 0;
    int    checks = 0;
    slot_t hist[$];
    int    scnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut_d1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .control_in(control_in), .rd_in(rd_in),
        .valid_out(v1), .data_out(d1), .control_out(c1), .rd_out(r1),
        .regwrite_eff(rw1), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.DEPTH(2)) u_dut_d2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .control_in(control_in), .rd_in(rd_in),
        .valid_out(v2), .data_out(d2), .control_out(c2), .rd_out(r2),
        .regwrite_eff(rw2), .stall_cnt(sc2)
    );

    pipe_stage_reg #(.DEPTH(3), .STALL_CNT_W(4)) u_dut_d3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .control_in(control_in), .rd_in(rd_in),
        .valid_out(v3), .data_out(d3), .control_out(c3), .rd_out(r3),
        .regwrite_eff(rw3), .stall_cnt(sc3)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: each edge that is not a pure stall records the slot it captures;
    // a DEPTH-d register shows the d-th most recent such slot.
    task automatic tick();
        slot_t s;
        if (!stall || flush) begin
            if (flush) begin
                s.valid = 1'b0; s.data = '0; s.rd = '0;
                s.ctrl  = control_in & 3'b010;
            end else if (!valid_in) begin
                s.valid = 1'b0; s.data = data_in; s.rd = rd_in;
                s.ctrl  = control_in & 3'b010;
            end else begin
                s.valid = 1'b1; s.data = data_in; s.rd = rd_in;
                s.ctrl  = control_in;
            end
            hist.push_front(s);
            if (hist.size() > 4) void'(hist.pop_back());
        end
        if (stall && !flush) scnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_dut(input string tag, input int d, input logic v,
                             input logic [127:0] dat, input logic [2:0] c,
                             input logic [4:0] r, input logic rw, input logic [15:0] sc);
        slot_t exp;
        int    cap;
        logic  exp_rw;
        exp    = (hist.size() >= d) ? hist[d-1] : '0;
        cap    = (d == 3) ? 15 : 65535;
        exp_rw = exp.valid && exp.ctrl[0] && (exp.rd != 5'd31);
        chk($sformatf("%s/d%0d/valid", tag, d), 128'(v), 128'(exp.valid));
        chk($sformatf("%s/d%0d/data", tag, d), dat, exp.data);
        chk($sformatf("%s/d%0d/ctrl", tag, d), 128'(c), 128'(exp.ctrl));
        chk($sformatf("%s/d%0d/rd", tag, d), 128'(r), 128'(exp.rd));
        chk($sformatf("%s/d%0d/regwrite_eff", tag, d), 128'(rw), 128'(exp_rw));
        chk($sformatf("%s/d%0d/stall_cnt", tag, d), 128'(sc),
            128'((scnt > cap) ? cap : scnt));
    endtask

    task automatic check_all(input string tag);
        check_dut(tag, 1, v1, d1, c1, r1, rw1, sc1);
        check_dut(tag, 2, v2, d2, c2, r2, rw2, sc2);
        check_dut(tag, 3, v3, d3, c3, r3, rw3, 16'(sc3));
    endtask

    task automatic set_in(input logic v, input logic [127:0] d, input logic [2:0] c,
                          input logic [4:0] r);
        valid_in = v; data_in = d; control_in = c; rd_in = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(1'b0, '0, 3'b000, 5'd0);
        #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        reset = 1'b0;

        // Pass-through
        set_in(1'b1, {64'hDEAD, 64'h1234}, 3'b011, 5'd5);
        tick(); check_all("pass");
        set_in(1'b1, {64'h1111, 64'h2222}, 3'b101, 5'd9);
        tick(); check_all("pass2");

        // Stall hold with changing inputs
        set_in(1'b1, {64'h7777, 64'h0007}, 3'b001, 5'd7);
        tick(); check_all("load7");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, {$urandom, $urandom, $urandom, $urandom}, 3'(i), 5'(i + 10));
            tick(); check_all($sformatf("stall%0d", i));
        end
        stall = 1'b0;
        set_in(1'b1, {64'hABCD, 64'h0013}, 3'b011, 5'd13);
        tick(); check_all("unstall");

        // Flush beats stall
        stall = 1'b1; flush = 1'b1;
        set_in(1'b1, {64'hFFFF, 64'hEEEE}, 3'b111, 5'd3);
        tick(); check_all("flush_stall");
        stall = 1'b0; flush = 1'b0;

        // XZR suppression
        set_in(1'b1, {64'h0, 64'h31}, 3'b001, 5'd31);
        tick(); check_all("xzr");
        // Invalid slot keeps data/rd, masks control
        set_in(1'b0, {64'h5555, 64'h6666}, 3'b111, 5'd4);
        tick(); check_all("invalid_in");

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_in(1'(($urandom_range(0, 4) != 0)),
                   {$urandom, $urandom, $urandom, $urandom},
                   3'($urandom_range(0, 7)),
                   ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
            tick(); check_all($sformatf("rand%0d", i));
        end

        // Saturation of the narrow counter, then a single op through depth 3
        stall = 1'b1; flush = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_all("sat");
        stall = 1'b0;
        set_in(1'b1, {64'hC0FFEE, 64'hBEEF}, 3'b011, 5'd21);
        tick(); check_all("op_e1");
        set_in(1'b0, '0, 3'b000, 5'd0);
        tick(); check_all("op_e2");
        tick(); check_all("op_e3");
        tick(); check_all("op_e4");

        // Reset between edges mid-flow
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, {$urandom, $urandom, $urandom, $urandom}, 3'b011, 5'(i + 1));
            tick();
        end
        check_all("pre_reset");
        #2 reset = 1'b1;
        #1;
        hist.delete();
        scnt = 0;
        check_all("reset_mid");
        #1 reset = 1'b0;
        set_in(1'b1, {64'h9, 64'h8}, 3'b001, 5'd2);
        tick(); check_all("post_reset1");
        tick(); check_all("post_reset2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
